// File: rtl/multicycle_core.sv
// multicycle_core: unpipelined RV32I-subset core, one instruction per
// FETCH/DECODE/EXEC[/MEM]/WB pass, with illegal-instruction and
// misalignment halt (TRAP).
//
// Ports:
//   clk, rst_n            core clock, asynchronous active-low reset
//   step                  (only with MULTICYCLE_CORE_STEP_EN) advance gate
//   imem_req/addr/ack/rdata   instruction fetch, ack sampled in the req cycle
//   dmem_req/we/addr/wdata/ack/rdata   data load/store, held until ack
//   dbg_sel/dbg_data      combinational register read (x0 and out-of-range
//                         indices read 0)
//   pc, state, trap       current PC, FSM encoding, halted flag
//
// Build option: define MULTICYCLE_CORE_STEP_EN to add the step input; FETCH
// then completes only on a cycle with step=1 and imem_ack=1.
module multicycle_core #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          NREGS    = 32
) (
  input  logic        clk,
  input  logic        rst_n,
`ifdef MULTICYCLE_CORE_STEP_EN
  input  logic        step,
`endif
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  input  logic [4:0]  dbg_sel,
  output logic [31:0] dbg_data,
  output logic [31:0] pc,
  output logic [2:0]  state,
  output logic        trap
);

  localparam int unsigned XLEN   = 32;
  localparam int unsigned NRF    = 32;
  localparam logic [5:0]  NREG_L = 6'(NREGS);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_e;

  state_e            r_state;
  state_e            w_state_nxt;
  logic [XLEN-1:0]   r_pc;
  logic [XLEN-1:0]   r_ir;
  logic [XLEN-1:0]   r_a;
  logic [XLEN-1:0]   r_b;
  logic [XLEN-1:0]   r_imm;
  logic [XLEN-1:0]   r_alu;
  // Sized to the full 5-bit index space; indices >= NREGS trap in DECODE,
  // so the upper half is never written when NREGS=16.
  logic [XLEN-1:0]   r_regs [NRF];

  logic              w_step_ok;
`ifdef MULTICYCLE_CORE_STEP_EN
  assign w_step_ok = step;
`else
  assign w_step_ok = 1'b1;
`endif

  // Instruction field decode from the instruction register
  logic [6:0] w_opcode;
  logic [4:0] w_rd;
  logic [2:0] w_f3;
  logic [4:0] w_rs1;
  logic [4:0] w_rs2;
  logic [6:0] w_f7;
  assign w_opcode = r_ir[6:0];
  assign w_rd     = r_ir[11:7];
  assign w_f3     = r_ir[14:12];
  assign w_rs1    = r_ir[19:15];
  assign w_rs2    = r_ir[24:20];
  assign w_f7     = r_ir[31:25];

  logic w_is_op, w_is_opimm, w_is_lui, w_is_auipc, w_is_load;
  logic w_is_store, w_is_branch, w_is_jal, w_is_jalr;
  assign w_is_op     = (w_opcode == OPC_OP);
  assign w_is_opimm  = (w_opcode == OPC_OPIMM);
  assign w_is_lui    = (w_opcode == OPC_LUI);
  assign w_is_auipc  = (w_opcode == OPC_AUIPC);
  assign w_is_load   = (w_opcode == OPC_LOAD);
  assign w_is_store  = (w_opcode == OPC_STORE);
  assign w_is_branch = (w_opcode == OPC_BRANCH);
  assign w_is_jal    = (w_opcode == OPC_JAL);
  assign w_is_jalr   = (w_opcode == OPC_JALR);

  // Supported encodings only; SLTU/SLTIU/byte/half accesses are illegal here
  logic w_legal;
  always_comb begin
    w_legal = 1'b0;
    if (w_is_op)
      w_legal = ((w_f7 == 7'd0) && (w_f3 != 3'b011)) ||
                ((w_f7 == F7_ALT) && ((w_f3 == 3'b000) || (w_f3 == 3'b101)));
    else if (w_is_opimm)
      w_legal = (w_f3 == 3'b000) || (w_f3 == 3'b010) || (w_f3 == 3'b100) ||
                (w_f3 == 3'b110) || (w_f3 == 3'b111) ||
                ((w_f3 == 3'b001) && (w_f7 == 7'd0)) ||
                ((w_f3 == 3'b101) && ((w_f7 == 7'd0) || (w_f7 == F7_ALT)));
    else if (w_is_lui || w_is_auipc || w_is_jal)
      w_legal = 1'b1;
    else if (w_is_load || w_is_store)
      w_legal = (w_f3 == 3'b010);
    else if (w_is_branch)
      w_legal = (w_f3 == 3'b000) || (w_f3 == 3'b001) ||
                (w_f3 == 3'b100) || (w_f3 == 3'b101);
    else if (w_is_jalr)
      w_legal = (w_f3 == 3'b000);
  end

  // Only register fields the format actually uses are range-checked
  logic w_uses_rd, w_uses_rs1, w_uses_rs2, w_idx_bad;
  assign w_uses_rd  = w_is_op | w_is_opimm | w_is_lui | w_is_auipc |
                      w_is_load | w_is_jal | w_is_jalr;
  assign w_uses_rs1 = w_is_op | w_is_opimm | w_is_load | w_is_store |
                      w_is_branch | w_is_jalr;
  assign w_uses_rs2 = w_is_op | w_is_store | w_is_branch;
  assign w_idx_bad  = (w_uses_rd  && ({1'b0, w_rd}  >= NREG_L)) ||
                      (w_uses_rs1 && ({1'b0, w_rs1} >= NREG_L)) ||
                      (w_uses_rs2 && ({1'b0, w_rs2} >= NREG_L));

  // Sign-extended immediate by format
  logic [XLEN-1:0] w_imm;
  always_comb begin
    w_imm = '0;
    if (w_is_opimm || w_is_load || w_is_jalr)
      w_imm = {{20{r_ir[31]}}, r_ir[31:20]};
    else if (w_is_store)
      w_imm = {{20{r_ir[31]}}, r_ir[31:25], r_ir[11:7]};
    else if (w_is_branch)
      w_imm = {{19{r_ir[31]}}, r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0};
    else if (w_is_lui || w_is_auipc)
      w_imm = {r_ir[31:12], 12'd0};
    else if (w_is_jal)
      w_imm = {{11{r_ir[31]}}, r_ir[31], r_ir[19:12], r_ir[20], r_ir[30:21], 1'b0};
  end

  logic [XLEN-1:0] w_rs1_val, w_rs2_val;
  assign w_rs1_val = (w_rs1 == 5'd0) ? '0 : r_regs[w_rs1];
  assign w_rs2_val = (w_rs2 == 5'd0) ? '0 : r_regs[w_rs2];

  // ALU on latched operands
  logic [XLEN-1:0] w_op2, w_alu, w_result;
  logic [4:0]      w_shamt;
  assign w_op2   = w_is_op ? r_b : r_imm;
  assign w_shamt = w_op2[4:0];
  always_comb begin
    w_alu = '0;
    case (w_f3)
      3'b000: w_alu = (w_is_op && w_f7[5]) ? (r_a - w_op2) : (r_a + w_op2);
      3'b001: w_alu = r_a << w_shamt;
      3'b010: w_alu = XLEN'($signed(r_a) < $signed(w_op2));
      3'b100: w_alu = r_a ^ w_op2;
      3'b101: w_alu = w_f7[5] ? XLEN'($signed(r_a) >>> w_shamt) : (r_a >> w_shamt);
      3'b110: w_alu = r_a | w_op2;
      3'b111: w_alu = r_a & w_op2;
      default: w_alu = '0;
    endcase
  end

  logic [XLEN-1:0] w_pc4, w_pc_imm, w_jalr_tgt, w_jump_tgt, w_addr;
  assign w_pc4      = r_pc + 32'd4;
  assign w_pc_imm   = r_pc + r_imm;
  assign w_addr     = r_a + r_imm;
  assign w_jalr_tgt = w_addr & ~32'd1;
  assign w_jump_tgt = w_is_jalr ? w_jalr_tgt : w_pc_imm;

  always_comb begin
    w_result = w_alu;
    if (w_is_lui)                     w_result = r_imm;
    else if (w_is_auipc)              w_result = w_pc_imm;
    else if (w_is_load || w_is_store) w_result = w_addr;
    else if (w_is_jal || w_is_jalr)   w_result = w_pc4;
  end

  logic w_taken;
  always_comb begin
    w_taken = 1'b0;
    case (w_f3)
      3'b000: w_taken = (r_a == r_b);
      3'b001: w_taken = (r_a != r_b);
      3'b100: w_taken = ($signed(r_a) < $signed(r_b));
      3'b101: w_taken = ($signed(r_a) >= $signed(r_b));
      default: w_taken = 1'b0;
    endcase
  end

  // Misaligned data address or control-transfer target halts before any request
  logic w_misaligned;
  assign w_misaligned = ((w_is_load || w_is_store) && (w_addr[1:0] != 2'b00)) ||
                        ((w_is_jal || w_is_jalr) && (w_jump_tgt[1:0] != 2'b00)) ||
                        (w_is_branch && w_taken && (w_pc_imm[1:0] != 2'b00));

  // Next-state and handshake outputs
  always_comb begin
    w_state_nxt = r_state;
    imem_req    = 1'b0;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    case (r_state)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack && w_step_ok) w_state_nxt = S_DECODE;
      end
      S_DECODE: w_state_nxt = (!w_legal || w_idx_bad) ? S_TRAP : S_EXEC;
      S_EXEC: begin
        if (w_misaligned)                 w_state_nxt = S_TRAP;
        else if (w_is_load || w_is_store) w_state_nxt = S_MEM;
        else if (w_is_branch)             w_state_nxt = S_FETCH;
        else                              w_state_nxt = S_WB;
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = w_is_store;
        if (dmem_ack) w_state_nxt = w_is_store ? S_FETCH : S_WB;
      end
      S_WB:    w_state_nxt = S_FETCH;
      S_TRAP:  w_state_nxt = S_TRAP;
      default: w_state_nxt = S_TRAP;
    endcase
    // Requests are suppressed for the whole time reset is held
    if (!rst_n) begin
      imem_req = 1'b0;
      dmem_req = 1'b0;
      dmem_we  = 1'b0;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
      r_pc    <= RESET_PC;
      r_ir    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_imm   <= '0;
      r_alu   <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_FETCH: if (imem_ack && w_step_ok) r_ir <= imem_rdata;
        S_DECODE: begin
          r_a   <= w_rs1_val;
          r_b   <= w_rs2_val;
          r_imm <= w_imm;
        end
        S_EXEC: begin
          r_alu <= w_result;
          if (w_is_branch && !w_misaligned) r_pc <= w_taken ? w_pc_imm : w_pc4;
        end
        S_MEM: begin
          if (dmem_ack) begin
            if (w_is_store) r_pc  <= w_pc4;
            else            r_alu <= dmem_rdata;
          end
        end
        S_WB: r_pc <= (w_is_jal || w_is_jalr) ? w_jump_tgt : w_pc4;
        default: ;
      endcase
    end
  end

  // Register file: not reset, x0 writes dropped
  always_ff @(posedge clk) begin
    if ((r_state == S_WB) && (w_rd != 5'd0)) r_regs[w_rd] <= r_alu;
  end

  assign dbg_data   = ((dbg_sel == 5'd0) || ({1'b0, dbg_sel} >= NREG_L)) ? '0 : r_regs[dbg_sel];
  assign imem_addr  = r_pc;
  assign dmem_addr  = r_alu;
  assign dmem_wdata = r_b;
  assign pc         = r_pc;
  assign state      = r_state;
  assign trap       = (r_state == S_TRAP);

endmodule

// File: tb/tb_multicycle_core.sv
// Directed self-checking bench for multicycle_core: a 32-register core at
// RESET_PC=0 with zero-wait instruction memory and a delay-configurable data
// memory, plus a 16-register core at RESET_PC=0x100.
module tb_multicycle_core;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Main core
  logic        rst_n = 1'b0;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_rdata;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [4:0]  dbg_sel = 5'd0;
  logic [31:0] dbg_data, pc;
  logic [2:0]  state;
  logic        trap;
  logic        step = 1'b1;

  // RV32E-style core
  logic        rst2_n = 1'b0;
  logic        imem_req2, imem_ack2;
  logic [31:0] imem_addr2, imem_rdata2;
  logic        dmem_req2, dmem_we2;
  logic [31:0] dmem_addr2, dmem_wdata2;
  logic [4:0]  dbg_sel2 = 5'd0;
  logic [31:0] dbg_data2, pc2;
  logic [2:0]  state2;
  logic        trap2;

  int checks = 0;
  int failures = 0;

  logic [31:0] imem [64];
  logic [31:0] dmem [64];
  int          dly = 0;
  int          dcnt = 0;
  logic [31:0] st_addr = '0, st_data = '0, ld_addr = '0;
  int          viol = 0, ireq_cnt = 0, dreq_cnt = 0;

  assign imem_ack   = imem_req;
  assign imem_rdata = imem[imem_addr[7:2]];
  assign dmem_ack   = dmem_req && (dcnt >= dly);
  assign dmem_rdata = dmem[dmem_addr[7:2]];

  assign imem_ack2   = imem_req2;
  assign imem_rdata2 = 32'h00100A13; // ADDI x20,x0,1

  // Data memory with programmable ack delay
  always @(posedge clk) begin
    if (!dmem_req || dmem_ack) dcnt <= 0;
    else                       dcnt <= dcnt + 1;
    if (dmem_req && dmem_ack) begin
      if (dmem_we) begin
        dmem[dmem_addr[7:2]] <= dmem_wdata;
        st_addr <= dmem_addr;
        st_data <= dmem_wdata;
      end else begin
        ld_addr <= dmem_addr;
      end
    end
  end

  // Port-rule monitor, sampled away from the active edge
  always @(negedge clk) begin
    if (imem_req && dmem_req) viol <= viol + 1;
    if (dmem_we && !dmem_req) viol <= viol + 1;
    if (imem_req) ireq_cnt <= ireq_cnt + 1;
    if (dmem_req) dreq_cnt <= dreq_cnt + 1;
  end

  multicycle_core #(.RESET_PC(32'h0000_0000), .NREGS(32)) u_dut (
    .clk(clk), .rst_n(rst_n),
`ifdef MULTICYCLE_CORE_STEP_EN
    .step(step),
`endif
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data), .pc(pc), .state(state), .trap(trap)
  );

  multicycle_core #(.RESET_PC(32'h0000_0100), .NREGS(16)) u_dut16 (
    .clk(clk), .rst_n(rst2_n),
`ifdef MULTICYCLE_CORE_STEP_EN
    .step(step),
`endif
    .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_ack(imem_ack2), .imem_rdata(imem_rdata2),
    .dmem_req(dmem_req2), .dmem_we(dmem_we2), .dmem_addr(dmem_addr2), .dmem_wdata(dmem_wdata2),
    .dmem_ack(1'b0), .dmem_rdata(32'd0),
    .dbg_sel(dbg_sel2), .dbg_data(dbg_data2), .pc(pc2), .state(state2), .trap(trap2)
  );

  task automatic clear_imem();
    for (int i = 0; i < 64; i++) imem[i] = 32'h0000006F; // JAL x0,0
  endtask

  // Hold reset across one rising edge, release on a falling edge
  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clear_imem();
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (state !== 3'd0) begin failures++; $display("FAIL rst_state got %0d want 0", state); end
    checks++; if (pc !== 32'h0) begin failures++; $display("FAIL rst_pc got %h want 0", pc); end
    checks++; if (trap !== 1'b0) begin failures++; $display("FAIL rst_trap got %b want 0", trap); end
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rst_ireq_held got %b want 0", imem_req); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL rst_first_req got %b want 1", imem_req); end
    checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL rst_first_addr got %h want 0", imem_addr); end
  endtask

  task automatic test_alu();
    clear_imem();
    imem[0] = 32'h00500093; // ADDI x1,x0,5
    imem[1] = 32'h00108133; // ADD  x2,x1,x1
    do_reset();
    cycles(8);
    dbg_sel = 5'd2; #1;
    checks++; if (dbg_data !== 32'd10) begin failures++; $display("FAIL alu_x2 got %h want 10", dbg_data); end
    dbg_sel = 5'd1; #1;
    checks++; if (dbg_data !== 32'd5) begin failures++; $display("FAIL alu_x1 got %h want 5", dbg_data); end
    checks++; if (pc !== 32'h8) begin failures++; $display("FAIL alu_pc got %h want 8", pc); end
  endtask

  task automatic test_alu_ops();
    clear_imem();
    imem[0] = 32'h00500093; // ADDI x1,x0,5
    imem[1] = 32'hFF000213; // ADDI x4,x0,-16
    imem[2] = 32'h40225293; // SRAI x5,x4,2
    imem[3] = 32'h00122333; // SLT  x6,x4,x1
    imem[4] = 32'h404083B3; // SUB  x7,x1,x4
    imem[5] = 32'h12345437; // LUI  x8,0x12345
    imem[6] = 32'h001254B3; // SRL  x9,x4,x1
    imem[7] = 32'h00700013; // ADDI x0,x0,7
    imem[8] = 32'h00100533; // ADD  x10,x0,x1
    do_reset();
    cycles(36);
    dbg_sel = 5'd5; #1;
    checks++; if (dbg_data !== 32'hFFFFFFFC) begin failures++; $display("FAIL srai got %h want fffffffc", dbg_data); end
    dbg_sel = 5'd6; #1;
    checks++; if (dbg_data !== 32'd1) begin failures++; $display("FAIL slt got %h want 1", dbg_data); end
    dbg_sel = 5'd7; #1;
    checks++; if (dbg_data !== 32'd21) begin failures++; $display("FAIL sub got %h want 15", dbg_data); end
    dbg_sel = 5'd8; #1;
    checks++; if (dbg_data !== 32'h12345000) begin failures++; $display("FAIL lui got %h want 12345000", dbg_data); end
    dbg_sel = 5'd9; #1;
    checks++; if (dbg_data !== 32'h07FFFFFF) begin failures++; $display("FAIL srl got %h want 07ffffff", dbg_data); end
    dbg_sel = 5'd10; #1;
    checks++; if (dbg_data !== 32'd5) begin failures++; $display("FAIL x0_read got %h want 5", dbg_data); end
    dbg_sel = 5'd0; #1;
    checks++; if (dbg_data !== 32'd0) begin failures++; $display("FAIL dbg_x0 got %h want 0", dbg_data); end
    checks++; if (pc !== 32'h24) begin failures++; $display("FAIL ops_pc got %h want 24", pc); end
  endtask

  task automatic test_mem();
    int n;
    clear_imem();
    imem[0] = 32'h00202223; // SW x2,4(x0)
    imem[1] = 32'h00402183; // LW x3,4(x0)
    dly = 2;
    do_reset();
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      cycles(1);
      if (pc == 32'h8) begin n = i; break; end
    end
    checks++; if (n != 13) begin failures++; $display("FAIL mem_cycles got %0d want 13", n); end
    checks++; if (st_addr !== 32'd4) begin failures++; $display("FAIL sw_addr got %h want 4", st_addr); end
    checks++; if (st_data !== 32'd10) begin failures++; $display("FAIL sw_wdata got %h want 10", st_data); end
    checks++; if (ld_addr !== 32'd4) begin failures++; $display("FAIL lw_addr got %h want 4", ld_addr); end
    dbg_sel = 5'd3; #1;
    checks++; if (dbg_data !== 32'd10) begin failures++; $display("FAIL lw_x3 got %h want 10", dbg_data); end
    dly = 0;
  endtask

  task automatic test_branch();
    clear_imem();
    imem[0] = 32'h010002EF; // JAL x5,16
    imem[4] = 32'hFE000CE3; // BEQ x0,x0,-8
    do_reset();
    cycles(4);
    checks++; if (pc !== 32'h10) begin failures++; $display("FAIL jal_pc got %h want 10", pc); end
    dbg_sel = 5'd5; #1;
    checks++; if (dbg_data !== 32'd4) begin failures++; $display("FAIL jal_link got %h want 4", dbg_data); end
    cycles(3);
    checks++; if (imem_addr !== 32'h08) begin failures++; $display("FAIL beq_addr got %h want 08", imem_addr); end
    checks++; if (state !== 3'd0 || imem_req !== 1'b1) begin failures++; $display("FAIL beq_fetch got state %0d req %b want 0 1", state, imem_req); end
    imem[4] = 32'hFE001CE3; // BNE x0,x0,-8
    do_reset();
    cycles(7);
    checks++; if (imem_addr !== 32'h14) begin failures++; $display("FAIL bne_addr got %h want 14", imem_addr); end
  endtask

  task automatic test_trap();
    int ir0, dr0;
    clear_imem();
    imem[0] = 32'h0000007F;
    do_reset();
    cycles(2);
    checks++; if (trap !== 1'b1) begin failures++; $display("FAIL ill_trap got %b want 1", trap); end
    checks++; if (state !== 3'd5) begin failures++; $display("FAIL ill_state got %0d want 5", state); end
    ir0 = ireq_cnt; dr0 = dreq_cnt;
    cycles(10);
    checks++; if (ireq_cnt != ir0 || dreq_cnt != dr0) begin failures++; $display("FAIL trap_quiet got %0d requests want 0", (ireq_cnt - ir0) + (dreq_cnt - dr0)); end
    checks++; if (pc !== 32'h0) begin failures++; $display("FAIL trap_pc got %h want 0", pc); end
    do_reset();
    #1;
    checks++; if (trap !== 1'b0 || state !== 3'd0) begin failures++; $display("FAIL trap_clear got trap %b state %0d want 0 0", trap, state); end
    imem[0] = 32'h00202183; // LW x3,2(x0)
    dr0 = dreq_cnt;
    do_reset();
    cycles(3);
    checks++; if (trap !== 1'b1 || state !== 3'd5) begin failures++; $display("FAIL mis_trap got trap %b state %0d want 1 5", trap, state); end
    cycles(4);
    checks++; if (dreq_cnt != dr0) begin failures++; $display("FAIL mis_noreq got %0d dmem requests want 0", dreq_cnt - dr0); end
  endtask

  task automatic test_midreset();
    clear_imem();
    imem[0] = 32'h00202223; // SW x2,4(x0)
    dly = 5;
    do_reset();
    cycles(3);
    checks++; if (dmem_req !== 1'b1 || dmem_we !== 1'b1) begin failures++; $display("FAIL mid_inflight got req %b we %b want 1 1", dmem_req, dmem_we); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (dmem_req !== 1'b0 || dmem_we !== 1'b0 || imem_req !== 1'b0) begin failures++; $display("FAIL mid_outputs got %b%b%b want 000", dmem_req, dmem_we, imem_req); end
    checks++; if (state !== 3'd0 || pc !== 32'h0) begin failures++; $display("FAIL mid_state got %0d pc %h want 0 0", state, pc); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin failures++; $display("FAIL mid_refetch got req %b addr %h want 1 0", imem_req, imem_addr); end
    dly = 0;
  endtask

  task automatic test_nregs16();
    checks++; if (imem_req2 !== 1'b0) begin failures++; $display("FAIL r16_held got %b want 0", imem_req2); end
    @(negedge clk);
    rst2_n = 1'b1;
    #1;
    checks++; if (imem_addr2 !== 32'h100 || imem_req2 !== 1'b1) begin failures++; $display("FAIL r16_fetch got req %b addr %h want 1 100", imem_req2, imem_addr2); end
    checks++; if (state2 !== 3'd0) begin failures++; $display("FAIL r16_state got %0d want 0", state2); end
    cycles(2);
    checks++; if (trap2 !== 1'b1 || state2 !== 3'd5) begin failures++; $display("FAIL r16_trap got trap %b state %0d want 1 5", trap2, state2); end
    dbg_sel2 = 5'd20; #1;
    checks++; if (dbg_data2 !== 32'd0) begin failures++; $display("FAIL r16_dbg got %h want 0", dbg_data2); end
  endtask

  task automatic test_protocol();
    checks++; if (viol != 0) begin failures++; $display("FAIL port_rules got %0d violations want 0", viol); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_alu();
    test_alu_ops();
    test_mem();
    test_branch();
    test_trap();
    test_midreset();
    test_nregs16();
    test_protocol();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_core.md
MULTICYCLE_CORE -- requirements
Module: multicycle_core

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded on reset.
REQ-002 The block SHALL have parameter NREGS, default 32 (legal 16 or 32), meaning the number of architectural registers (16 gives an RV32E-style file).
REQ-003 The block SHALL have port clk, input, 1 bit: the single core clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 Instruction port SHALL be imem_req out 1 (fetch request), imem_addr out 32 (byte address), imem_ack in 1 (data valid, sampled same cycle as req), imem_rdata in 32 (instruction word).
REQ-006 Data port SHALL be dmem_req out 1, dmem_we out 1, dmem_addr out 32, dmem_wdata out 32, dmem_ack in 1, dmem_rdata in 32.
REQ-007 Debug port SHALL be dbg_sel in 5 (register index), dbg_data out 32 (combinational register read), pc out 32 (current PC), state out 3 (FSM encoding), trap out 1 (illegal-instruction halt).

Function
REQ-008 FSM states SHALL be FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.
REQ-009 FETCH: imem_req=1 and imem_addr=pc; on a clock edge with imem_ack=1, the instruction register SHALL load imem_rdata and the FSM SHALL go to DECODE; otherwise it SHALL stay in FETCH.
REQ-010 DECODE: rs1/rs2 SHALL be latched into A/B and the immediate (I/S/B/U/J formats, sign-extended) latched; an unsupported opcode or rd/rs index >= NREGS SHALL go to TRAP, else EXEC.
REQ-011 Supported ops SHALL be ADD SUB AND OR XOR SLT SLL SRL SRA (R-type), ADDI ANDI ORI XORI SLTI SLLI SRLI SRAI, LUI, AUIPC, LW, SW, BEQ, BNE, BLT, BGE, JAL, JALR.
REQ-012 EXEC: ALU result SHALL be latched; LW/SW go to MEM; branches, if taken, SHALL set pc=pc+imm, else pc=pc+4, then go to FETCH (3-cycle branch with zero-wait memory); all other ops go to WB.
REQ-013 MEM: dmem_req=1, dmem_addr=ALU result, dmem_we=1 for SW with dmem_wdata=rs2; hold until dmem_ack=1; SW then sets pc=pc+4 and goes to FETCH, LW latches dmem_rdata and goes to WB.
REQ-014 WB: rd SHALL be written (ALU result, load data, or pc+4 for JAL/JALR); pc SHALL update (pc+4, pc+imm for JAL, (rs1+imm)&~1 for JALR); next state FETCH.
REQ-015 Zero-wait CPI SHALL be 4 for ALU/jump ops, 5 for LW, 4 for SW, 3 for branches.
REQ-016 Writes to x0 SHALL be discarded; reads of x0 and dbg_sel=0 SHALL return 0; dbg_sel >= NREGS SHALL return 0.
REQ-017 All arithmetic SHALL be 32-bit modulo 2^32; shifts SHALL use the low 5 bits of the amount; SLT/BLT/BGE signed.
REQ-018 Misaligned addresses (low 2 bits nonzero) on LW/SW or a jump target SHALL go to TRAP without issuing the request.
REQ-019 TRAP SHALL be absorbing: trap=1, no requests, pc frozen, until reset.
REQ-020 imem_req and dmem_req SHALL never be high in the same cycle; dmem_we SHALL be 0 whenever dmem_req=0.

Reset
REQ-021 rst_n=0 SHALL asynchronously force state=FETCH, pc=RESET_PC, trap=0, instruction register=0; the register file SHALL NOT be reset.
REQ-022 Reset asserted mid-handshake SHALL abandon the transaction; outputs SHALL be req=0 and we=0 while rst_n=0, and the first request after release SHALL be a fetch at RESET_PC.

Configuration
REQ-023 With macro MULTICYCLE_CORE_STEP_EN defined, an extra input step (1 bit) SHALL exist and the FSM SHALL leave FETCH only when step=1 and imem_ack=1 (one instruction per step pulse); without it, no step port and free running.

Verification
REQ-024 Reset with RESET_PC=32'h100 -> first imem_addr=32'h100, imem_req=1, state=0.
REQ-025 ADDI x1,x0,5 then ADD x2,x1,x1, zero-wait -> dbg_sel=2 reads 32'd10 after 8 cycles.
REQ-026 SW x2,4(x0) then LW x3,4(x0) with a memory model delaying dmem_ack by 2 cycles -> dmem_addr=4, dmem_wdata=10, x3=10, pc advanced by 8.
REQ-027 BEQ x0,x0,-8 at pc=32'h10 -> next fetch at 32'h08 after 3 cycles; BNE x0,x0 -> 32'h14.
REQ-028 Opcode 7'h7F, or LW at address 2 -> trap=1, state=5, no further req; rst_n pulse clears trap.
REQ-029 NREGS=16 and ADDI x20,x0,1 -> trap=1.
